// File: rtl/hamming_pkg.sv
// Shared Hamming(21,16) definitions for the serial link encoder and decoder.
// Codeword positions are 1-based; position p is stored in bit [p-1].
package hamming_pkg;

  localparam int DATA_W = 16;
  localparam int CODE_W = 21;
  localparam int PAR_W  = 5;

  localparam logic [PAR_W-1:0] SYN_MAX_VALID = 5'd21;
  localparam logic [PAR_W-1:0] SYN_MIN_UNC   = 5'd22;

  // Codeword position (1..CODE_W) of data bit idx; parity occupies the powers of two.
  function automatic int dataPos(input int idx);
    int pos;
    int cnt;
    pos = 0;
    cnt = 0;
    for (int p = 1; p <= CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  function automatic logic [DATA_W-1:0] extractData(input logic [CODE_W-1:0] cw);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < DATA_W; i++) d[i] = cw[5'(dataPos(i) - 1)];
    return d;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational Hamming(21,16) decode: syndrome, single-error correction and
// extraction of the data word.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] codeword,
  output logic [PAR_W-1:0]  syndrome,
  output logic [DATA_W-1:0] data,
  output logic              corrected,
  output logic              uncorrectable
);

  logic [CODE_W-1:0] fixedWord;

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    syndrome      = '0;
    fixedWord     = codeword;
    corrected     = 1'b0;
    uncorrectable = 1'b0;
    for (int p = 1; p <= CODE_W; p++) begin
      if (codeword[5'(p - 1)]) syndrome = syndrome ^ 5'(p);
    end
    if (syndrome != '0 && syndrome <= SYN_MAX_VALID) begin
      fixedWord[syndrome - 5'd1] = ~codeword[syndrome - 5'd1];
      corrected = 1'b1;
    end else if (syndrome >= SYN_MIN_UNC) begin
      uncorrectable = 1'b1;
    end
    data = extractData(fixedWord);
  end

endmodule

// File: rtl/hamming_serial_rx.sv
// Receive end of the Hamming(21,16) serial link: deserializer FSM, registered
// decode stage, one-entry valid/ready output buffer and saturating statistics.
module hamming_serial_rx
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iSerValid,
  input  logic              iSerData,
  input  logic              iSerStart,
  output logic [DATA_W-1:0] oData,
  output logic              oValid,
  input  logic              iReady,
  output logic [PAR_W-1:0]  oSyndrome,
  output logic              oCorrected,
  output logic              oUncorrectable,
  output logic              oOverrun,
  output logic [CNT_W-1:0]  oCorrCnt,
  output logic [CNT_W-1:0]  oUncCnt,
  output logic [CNT_W-1:0]  oOvrCnt
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;
  localparam logic [4:0] LAST_BIT = 5'(CODE_W - 1);

  logic [0:0]        state;
  logic [4:0]        bitCnt;
  logic [CODE_W-1:0] shiftReg;
  logic [CODE_W-1:0] decReg;
  logic              decValid;
  logic              decPending;
  logic [DATA_W-1:0] decData;
  logic [PAR_W-1:0]  decSyn;
  logic              decCorr;
  logic              decUnc;

  logic [DATA_W-1:0] synData;
  logic [PAR_W-1:0]  synValue;
  logic              synCorr;
  logic              synUnc;
  logic              canLoad;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      bitCnt   <= '0;
      shiftReg <= '0;
      decReg   <= '0;
      decValid <= 1'b0;
    end else begin
      decValid <= 1'b0;
      if (iSerValid) begin
        if (iSerStart) begin
          // A start bit always opens a new frame, silently dropping any partial one.
          state    <= ST_SHIFT;
          shiftReg <= {{(CODE_W-1){1'b0}}, iSerData};
          bitCnt   <= 5'd1;
        end else if (state == ST_SHIFT) begin
          if (bitCnt == LAST_BIT) begin
            decReg   <= {iSerData, shiftReg[CODE_W-2:0]};
            decValid <= 1'b1;
            state    <= ST_IDLE;
            bitCnt   <= '0;
          end else begin
            shiftReg[bitCnt] <= iSerData;
            bitCnt           <= bitCnt + 5'd1;
          end
        end
      end
    end
  end

  hamming_syndrome uSyndrome (
    .codeword      (decReg),
    .syndrome      (synValue),
    .data          (synData),
    .corrected     (synCorr),
    .uncorrectable (synUnc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      decPending <= 1'b0;
      decData    <= '0;
      decSyn     <= '0;
      decCorr    <= 1'b0;
      decUnc     <= 1'b0;
    end else begin
      decPending <= decValid;
      if (decValid) begin
        decData <= synData;
        decSyn  <= synValue;
        decCorr <= synCorr;
        decUnc  <= synUnc;
      end
    end
  end

  assign canLoad = !oValid || iReady;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oValid         <= 1'b0;
      oData          <= '0;
      oSyndrome      <= '0;
      oCorrected     <= 1'b0;
      oUncorrectable <= 1'b0;
      oOverrun       <= 1'b0;
      oCorrCnt       <= '0;
      oUncCnt        <= '0;
      oOvrCnt        <= '0;
    end else if (decPending && canLoad) begin
      oValid         <= 1'b1;
      oData          <= decData;
      oSyndrome      <= decSyn;
      oCorrected     <= decCorr;
      oUncorrectable <= decUnc;
      if (decCorr && oCorrCnt != {CNT_W{1'b1}}) oCorrCnt <= oCorrCnt + CNT_W'(1);
      if (decUnc && oUncCnt != {CNT_W{1'b1}})   oUncCnt  <= oUncCnt + CNT_W'(1);
    end else if (decPending) begin
      // Buffer is held by the consumer: the new word is lost and only the overrun stats move.
      oOverrun <= 1'b1;
      if (oOvrCnt != {CNT_W{1'b1}}) oOvrCnt <= oOvrCnt + CNT_W'(1);
    end else if (oValid && iReady) begin
      oValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Self-checking bench for hamming_serial_rx: directed frames from the test plan
// plus randomized traffic, checked every cycle against a behavioural link model.
module tb_hamming_serial_rx;

  typedef struct {
    logic [15:0] d;
    logic [4:0]  s;
    logic        c;
    logic        u;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iSerValid = 1'b0;
  logic        iSerData = 1'b0;
  logic        iSerStart = 1'b0;
  logic        iReady = 1'b0;
  logic [15:0] oData;
  logic        oValid;
  logic [4:0]  oSyndrome;
  logic        oCorrected;
  logic        oUncorrectable;
  logic        oOverrun;
  logic [15:0] oCorrCnt;
  logic [15:0] oUncCnt;
  logic [15:0] oOvrCnt;

  int nCmp = 0;
  int nMis = 0;
  int cyc = 0;
  int hsCount = 0;
  int readyPct = 100;

  exp_t expQ[$];
  exp_t mWord;
  bit   mValid = 1'b0;
  bit   mOverrun = 1'b0;
  int   mCorr = 0;
  int   mUnc = 0;
  int   mOvr = 0;
  bit   rdyPrev = 1'b0;

  hamming_serial_rx #(.CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .iSerValid      (iSerValid),
    .iSerData       (iSerData),
    .iSerStart      (iSerStart),
    .oData          (oData),
    .oValid         (oValid),
    .iReady         (iReady),
    .oSyndrome      (oSyndrome),
    .oCorrected     (oCorrected),
    .oUncorrectable (oUncorrectable),
    .oOverrun       (oOverrun),
    .oCorrCnt       (oCorrCnt),
    .oUncCnt        (oUncCnt),
    .oOvrCnt        (oOvrCnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit isPow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  function automatic logic [20:0] modelEncode(input logic [15:0] d);
    logic [20:0] cw;
    int k;
    cw = '0;
    k = 0;
    for (int p = 1; p <= 21; p++) begin
      if (!isPow2(p)) begin
        cw[5'(p - 1)] = d[4'(k)];
        k++;
      end
    end
    for (int b = 0; b < 5; b++) begin
      bit par;
      par = 1'b0;
      for (int p = 1; p <= 21; p++) if (((p >> b) & 1) == 1 && cw[5'(p - 1)]) par = ~par;
      cw[5'((1 << b) - 1)] = par;
    end
    return cw;
  endfunction

  function automatic logic [15:0] modelData(input logic [20:0] cw);
    logic [15:0] d;
    int k;
    d = '0;
    k = 0;
    for (int p = 1; p <= 21; p++) begin
      if (!isPow2(p)) begin
        d[4'(k)] = cw[5'(p - 1)];
        k++;
      end
    end
    return d;
  endfunction

  // Syndrome bit b is the even-parity check over every position whose index has bit b set.
  function automatic exp_t modelDecode(input logic [20:0] cw);
    exp_t e;
    logic [20:0] fix;
    int s;
    s = 0;
    for (int b = 0; b < 5; b++) begin
      bit par;
      par = 1'b0;
      for (int p = 1; p <= 21; p++) if (((p >> b) & 1) == 1 && cw[5'(p - 1)]) par = ~par;
      if (par) s = s | (1 << b);
    end
    fix = cw;
    e.c = 1'b0;
    e.u = 1'b0;
    e.s = 5'(s);
    e.due = 0;
    if (s >= 1 && s <= 21) begin
      fix[5'(s - 1)] = ~fix[5'(s - 1)];
      e.c = 1'b1;
    end else if (s > 21) begin
      e.u = 1'b1;
    end
    e.d = modelData(fix);
    return e;
  endfunction

  // Per-cycle model of the output port, updated after each rising edge.
  always @(negedge clk) begin
    bit accept;
    exp_t e;
    if (!rst) begin
      mValid = 1'b0;
      mOverrun = 1'b0;
      mCorr = 0;
      mUnc = 0;
      mOvr = 0;
      expQ.delete();
      check("rst_word", {7'd0, oValid, oData, oSyndrome, oCorrected, oUncorrectable, oOverrun}, 32'd0);
      check("rst_cnt", {16'd0, oCorrCnt | oUncCnt | oOvrCnt}, 32'd0);
    end else begin
      accept = mValid && rdyPrev;
      while (expQ.size() > 0 && expQ[0].due < cyc) begin
        e = expQ.pop_front();
        check("arrival_missed", 32'(e.due), 32'(cyc));
      end
      if (expQ.size() > 0 && expQ[0].due == cyc) begin
        e = expQ.pop_front();
        if (!mValid || accept) begin
          mWord = e;
          mValid = 1'b1;
          if (e.c) mCorr++;
          if (e.u) mUnc++;
        end else begin
          mOverrun = 1'b1;
          mOvr++;
        end
      end else if (accept) begin
        mValid = 1'b0;
      end
      check("oValid", 32'(oValid), 32'(mValid));
      if (mValid) begin
        check("oData", 32'(oData), 32'(mWord.d));
        check("oSyndrome", 32'(oSyndrome), 32'(mWord.s));
        check("oCorrected", 32'(oCorrected), 32'(mWord.c));
        check("oUncorrectable", 32'(oUncorrectable), 32'(mWord.u));
      end
      check("oOverrun", 32'(oOverrun), 32'(mOverrun));
      check("oCorrCnt", 32'(oCorrCnt), 32'(mCorr));
      check("oUncCnt", 32'(oUncCnt), 32'(mUnc));
      check("oOvrCnt", 32'(oOvrCnt), 32'(mOvr));
      if (oValid && iReady) hsCount++;
    end
    rdyPrev = iReady;
  end

  task automatic driveBit(input bit v, input bit st, input bit d);
    @(posedge clk);
    #1;
    iSerValid = v;
    iSerStart = st;
    iSerData = d;
    iReady = ($urandom_range(0, 99) < 32'(readyPct));
  endtask

  task automatic idle(input int n);
    repeat (n) driveBit(1'b0, 1'b0, 1'b0);
  endtask

  task automatic sendFrame(input logic [20:0] cw, input bit gaps);
    exp_t e;
    for (int p = 0; p < 21; p++) begin
      if (gaps && $urandom_range(0, 9) == 0) idle(int'($urandom_range(1, 3)));
      driveBit(1'b1, p == 0, cw[5'(p)]);
    end
    e = modelDecode(cw);
    e.due = cyc + 3;
    expQ.push_back(e);
  endtask

  task automatic sendPartial(input int nBits);
    for (int p = 0; p < nBits; p++) driveBit(1'b1, p == 0, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    int h0;
    logic [20:0] cw;
    exp_t pin;

    pin = modelDecode(21'h000017);
    check("pin_enc_0001", 32'(modelEncode(16'h0001)), 32'h000007);
    check("pin_syn_pos5", 32'(pin.s), 32'd5);
    check("pin_data_pos5", 32'(pin.d), 32'h0001);
    pin = modelDecode(21'h008020);
    check("pin_syn_unc", 32'(pin.s), 32'd22);
    check("pin_data_unc", 32'(pin.d), 32'h0004);
    check("pin_flag_unc", {pin.c, pin.u}, 32'b01);

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(3);

    h0 = hsCount;
    sendFrame(21'h000007, 1'b0);
    idle(6);
    check("t1_handshakes", 32'(hsCount - h0), 32'd1);

    sendFrame(21'h000017, 1'b0);
    idle(6);
    check("t2_corrcnt", 32'(oCorrCnt), 32'd1);

    sendFrame(21'h008020, 1'b0);
    idle(6);
    check("t3_unccnt", 32'(oUncCnt), 32'd1);

    h0 = hsCount;
    for (int i = 0; i < 8; i++) sendFrame(modelEncode(16'($urandom())), 1'b0);
    idle(6);
    check("b2b_handshakes", 32'(hsCount - h0), 32'd8);
    check("b2b_overrun", 32'(oOverrun), 32'd0);

    h0 = hsCount;
    sendPartial(10);
    sendFrame(21'h000007, 1'b0);
    idle(6);
    check("resync_handshakes", 32'(hsCount - h0), 32'd1);

    readyPct = 0;
    sendFrame(21'h000000, 1'b0);
    sendFrame(21'h000000, 1'b0);
    idle(4);
    check("ovr_sticky", 32'(oOverrun), 32'd1);
    check("ovr_count", 32'(oOvrCnt), 32'd1);
    h0 = hsCount;
    readyPct = 100;
    idle(6);
    check("ovr_release_handshakes", 32'(hsCount - h0), 32'd1);

    h0 = hsCount;
    sendPartial(10);
    #1 rst = 1'b0;
    idle(2);
    #1 rst = 1'b1;
    idle(30);
    check("midreset_handshakes", 32'(hsCount - h0), 32'd0);

    readyPct = 80;
    for (int f = 0; f < 40; f++) begin
      int kind;
      int a;
      int b;
      cw = modelEncode(16'($urandom()));
      kind = int'($urandom_range(0, 3));
      a = int'($urandom_range(0, 20));
      b = (a + int'($urandom_range(1, 20))) % 21;
      if (kind == 1 || kind == 2) cw[5'(a)] = ~cw[5'(a)];
      if (kind == 3) begin
        cw[5'(a)] = ~cw[5'(a)];
        cw[5'(b)] = ~cw[5'(b)];
      end
      if ($urandom_range(0, 7) == 0) sendPartial(int'($urandom_range(2, 15)));
      sendFrame(cw, 1'b1);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(0, 4)));
    end

    readyPct = 100;
    idle(10);
    check("drain_queue", 32'(expQ.size()), 32'd0);
    check("drain_valid", 32'(oValid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
    $finish;
  end

endmodule

// File: doc/hamming_serial_rx.md
# hamming_serial_rx

Receive end of the Hamming(21,16) serial link. It deserializes a 1-bit stream of 21-bit codewords and decodes each one, correcting any single-bit error. Each recovered 16-bit word is presented on a valid/ready output port together with its error status. It sits between the line interface and the data consumer, opposite the encoder/serializer on the transmit side, and keeps saturating statistics counters for link monitoring.

## Interface
- CNT_W, 16, width of the corrected/uncorrectable/overrun statistics counters (saturating)
- clk  input  1  system clock; all logic is on the rising edge
- rst  input  1  asynchronous reset, active-low
- iSerValid  input  1  qualifies iSerData/iSerStart this cycle
- iSerData  input  1  serial codeword bit, position 1 first
- iSerStart  input  1  marks the first bit (position 1) of a codeword; valid only with iSerValid
- oData  output  16  decoded, corrected data word
- oValid  output  1  oData and status are valid
- iReady  input  1  consumer accepts the word when oValid && iReady
- oSyndrome  output  5  syndrome of the presented word
- oCorrected  output  1  a single-bit error was corrected
- oUncorrectable  output  1  syndrome in 22..31; oData is raw and uncorrected
- oOverrun  output  1  sticky; set when a decoded word is dropped
- oCorrCnt, oUncCnt, oOvrCnt  output  CNT_W  saturating event counters

## Operation
- Codeword layout: positions 1..21, stored in bit [pos-1]. Parity bits sit at positions 1, 2, 4, 8, 16. Data bits 0..15 fill the remaining positions 3, 5, 6, 7, 9..15, 17..21 in ascending order. Parity is even.
- Receive FSM:
  - IDLE → SHIFT when iSerValid && iSerStart; that bit is position 1 and bitcnt is set to 1.
  - In SHIFT, each iSerValid bit is stored at position bitcnt+1.
  - iSerValid && iSerStart in SHIFT restarts the frame (resync); the partial frame is discarded without being counted.
  - iSerValid without iSerStart in IDLE is ignored.
  - When the 21st bit is stored, the codeword is copied into the decode register, the FSM returns to IDLE and decPending is set for one cycle.
- Decode stage:
  - syndrome = XOR of the positions of all set bits.
  - 0: no error.
  - 1..21: flip that position, then extract data; oCorrected=1. This applies even when the flipped position is a parity bit.
  - 22..31: extract raw data; oUncorrectable=1.
- Output buffer: a one-entry register. When decPending is set and the buffer is empty, or is emptying this cycle (oValid && iReady), it loads and oValid=1. Otherwise the new word is dropped: oOverrun sets and oOvrCnt increments.
- Counters increment once per word loaded into the buffer (corr/unc), or once per dropped word (ovr), and saturate at all-ones. Dropped words do not update corr/unc.
- oData and all status outputs stay stable while oValid && !iReady.

## Timing
- Reset values:
  - FSM = IDLE, bitcnt = 0, decPending = 0.
  - oValid = 0, oData = 0, oSyndrome = 0.
  - oCorrected, oUncorrectable and oOverrun = 0; all counters = 0.
- Reset applied mid-frame or mid-handshake discards all state immediately. No output is produced for the interrupted frame.
- Latency: oValid rises on the 2nd rising edge after the edge that samples bit 21.
- Back-to-back frames at one bit per cycle (a start bit immediately after bit 21) are sustained without overrun, provided iReady is held at 1.
- Simultaneous accept and load in one cycle: the buffer reloads and oValid stays 1.
- oOverrun clears only on reset.

## Structure
- Package hamming_pkg holds:
  - DATA_W=16, CODE_W=21, PAR_W=5;
  - the data-to-position map function;
  - the syndrome range constants (SYN_MAX_VALID=21).
  The encoder side shares this package.
- Sub-module hamming_syndrome: combinational block mapping a 21-bit codeword to {syndrome, corrected data, corrected flag, uncorrectable flag}.
- The top level holds the receive FSM, shift register, output buffer and counters.

## Test plan
- Serialize codeword 21'h000007, iReady=1 → oData=16'h0001, oSyndrome=0, oCorrected=0, oValid high for 1 cycle exactly 2 edges after bit 21.
- Serialize 21'h000017 (position 5 flipped) → oData=16'h0001, oSyndrome=5, oCorrected=1, oCorrCnt=1.
- Serialize 21'h008020 → oSyndrome=22, oUncorrectable=1, oData=16'h0004, oUncCnt=1.
- Hold iReady=0 and send two complete frames of 21'h000000 → first word held stable, second dropped, oOverrun=1, oOvrCnt=1. Raising iReady afterwards yields exactly one handshake.
- Send 10 bits, then iSerStart with a fresh frame of 21'h000007 → exactly one output, 16'h0001. Assert rst mid-frame → no output, all outputs return to reset values.
- Send 8 back-to-back frames with iReady=1 → 8 outputs, oOverrun stays 0.
